predicate_sender: RTL

- Producer end of the predicate operand path, placed at the output of an execution tile's ALU.
- Accepts completed test-instruction results (teq/tlt/etc. outcome plus 1–2 targets) and buffers them in a small FIFO.
- Serializes each result into one operand-network packet per valid target. Each packet carries an operand_t whose data[0] is the predicate bit, for delivery to a consumer reservation station's p slot.

---
 rtl/predicate_sender.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/predicate_sender.sv
`default_nettype none
// ============================================================================
// Module      : predicate_sender
// Description : Producer end of the predicate operand path. Buffers completed
//               test-instruction results in a small FIFO and serialises each
//               one into an operand packet per valid target, carrying the
//               predicate bit in op_data[0].
// Revision    : 1.0 - initial release
// ============================================================================
module predicate_sender #(
   parameter int DATA_W = 64,
   parameter int TGT_W  = 9,
   parameter int BID_W  = 3,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              res_valid,
   output logic              res_ready,
   input  logic              res_cond,
   input  logic              res_null,
   input  logic [BID_W-1:0]  res_bid,
   input  logic              res_t0_vld,
   input  logic [TGT_W-1:0]  res_t0,
   input  logic              res_t1_vld,
   input  logic [TGT_W-1:0]  res_t1,
   output logic              op_valid,
   input  logic              op_ready,
   output logic [DATA_W-1:0] op_data,
   output logic              op_null,
   output logic [BID_W-1:0]  op_bid,
   output logic [TGT_W-1:0]  op_tgt,
   output logic [15:0]       sent_cnt,
   output logic [7:0]        drop_cnt
);

   localparam int c_AW    = $clog2(DEPTH);
   localparam int c_ENT_W = 4 + BID_W + 2 * TGT_W;

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_SEND0 = 2'd1;
   localparam logic [1:0] c_SEND1 = 2'd2;

   // Entry layout: {cond, null, bid, t0_vld, t0, t1_vld, t1}
   logic [c_ENT_W-1:0] r_mem [DEPTH];
   logic [c_AW:0]      r_wr_ptr;
   logic [c_AW:0]      r_rd_ptr;
   logic [1:0]         r_state;

   logic               r_op_valid;
   logic [DATA_W-1:0]  r_op_data;
   logic               r_op_null;
   logic [BID_W-1:0]   r_op_bid;
   logic [TGT_W-1:0]   r_op_tgt;
   logic [15:0]        r_sent_cnt;
   logic [7:0]         r_drop_cnt;

   logic               w_full;
   logic               w_empty;
   logic               w_push;
   logic               w_pop;
   logic               w_drop;
   logic [c_ENT_W-1:0] w_res_ent;
   logic [c_ENT_W-1:0] w_head;
   logic               w_head_cond;
   logic               w_head_null;
   logic [BID_W-1:0]   w_head_bid;
   logic               w_head_t0_vld;
   logic [TGT_W-1:0]   w_head_t0;
   logic               w_head_t1_vld;
   logic [TGT_W-1:0]   w_head_t1;
   logic [DATA_W-1:0]  w_head_data;

   // Occupancy flags come only from registered pointers, so res_ready never
   // depends combinationally on op_ready.
   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                      (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
   assign res_ready = !w_full;
   assign w_push    = res_valid && !w_full && !flush;

   assign w_res_ent = {res_cond, res_null, res_bid, res_t0_vld, res_t0, res_t1_vld, res_t1};
   assign w_head    = r_mem[r_rd_ptr[c_AW-1:0]];
   assign {w_head_cond, w_head_null, w_head_bid, w_head_t0_vld, w_head_t0,
           w_head_t1_vld, w_head_t1} = w_head;
   assign w_head_data = {{(DATA_W-1){1'b0}}, w_head_cond};

   // Entries with no valid target are retired directly from IDLE.
   assign w_drop = (r_state == c_IDLE) && !w_empty && !w_head_t0_vld && !w_head_t1_vld;

   // Head is retired after its last packet handshakes or when it is dropped.
   always_comb begin
      w_pop = 1'b0;
      case (r_state)
         c_IDLE:  w_pop = w_drop;
         c_SEND0: w_pop = op_ready && !w_head_t1_vld;
         c_SEND1: w_pop = op_ready;
         default: w_pop = 1'b0;
      endcase
   end

   // FIFO storage write; contents need no reset because pointers gate reads.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[c_AW-1:0]] <= w_res_ent;
      end
   end

   // Push/pop pointer update; flush empties the FIFO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);
      end
   end

   // Send FSM with registered operand outputs, held stable while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= c_IDLE;
         r_op_valid <= 1'b0;
         r_op_data  <= '0;
         r_op_null  <= 1'b0;
         r_op_bid   <= '0;
         r_op_tgt   <= '0;
      end else if (flush) begin
         r_state    <= c_IDLE;
         r_op_valid <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (!w_empty && (w_head_t0_vld || w_head_t1_vld)) begin
                  r_state    <= w_head_t0_vld ? c_SEND0 : c_SEND1;
                  r_op_valid <= 1'b1;
                  r_op_tgt   <= w_head_t0_vld ? w_head_t0 : w_head_t1;
                  r_op_data  <= w_head_data;
                  r_op_null  <= w_head_null;
                  r_op_bid   <= w_head_bid;
               end
            end
            c_SEND0: begin
               if (op_ready) begin
                  if (w_head_t1_vld) begin
                     r_state  <= c_SEND1;
                     r_op_tgt <= w_head_t1;
                  end else begin
                     r_state    <= c_IDLE;
                     r_op_valid <= 1'b0;
                  end
               end
            end
            c_SEND1: begin
               if (op_ready) begin
                  r_state    <= c_IDLE;
                  r_op_valid <= 1'b0;
               end
            end
            default: begin
               r_state    <= c_IDLE;
               r_op_valid <= 1'b0;
            end
         endcase
      end
   end

   // Statistics: handshakes wrap, drops saturate; flush does not clear them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sent_cnt <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (r_op_valid && op_ready) r_sent_cnt <= r_sent_cnt + 16'd1;
         if (w_drop && !flush && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
      end
   end

   assign op_valid = r_op_valid;
   assign op_data  = r_op_data;
   assign op_null  = r_op_null;
   assign op_bid   = r_op_bid;
   assign op_tgt   = r_op_tgt;
   assign sent_cnt = r_sent_cnt;
   assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire
